// File: rtl/hello_msg_sequencer_if.sv
// Handshake bundle between the step source and the HELLO character sequencer.
// The master drives step/clear/loop_en; the sequencer drives the character stream.
interface hello_msg_sequencer_if #(
    parameter int CW = 3
);
    logic          step;
    logic          clear;
    logic          loop_en;
    logic [CW-1:0] char_code;
    logic          char_valid;
    logic          msg_start;
    logic          done;

    modport master (
        output step, clear, loop_en,
        input  char_code, char_valid, msg_start, done
    );

    modport slave (
        input  step, clear, loop_en,
        output char_code, char_valid, msg_start, done
    );
endinterface

// File: rtl/hello_msg_sequencer.sv
// Character source for the 8-digit HELLO shift display: emits H,E,L,L,O, GAP_LEN blanks,
// then either repeats or parks on blanks. One registered code per accepted step.
module hello_msg_sequencer #(
    parameter int GAP_LEN = 3,
    parameter int CW      = 3
) (
    input logic                  KEY,
    input logic                  SW,
    hello_msg_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] S_H  = 3'd1;
    localparam logic [2:0] S_E  = 3'd2;
    localparam logic [2:0] S_L1 = 3'd3;
    localparam logic [2:0] S_L2 = 3'd4;
    localparam logic [2:0] S_O  = 3'd5;
    localparam logic [2:0] GAP  = 3'd6;
    localparam logic [2:0] DONE = 3'd7;

    localparam logic [CW-1:0] CODE_H     = CW'(0);
    localparam logic [CW-1:0] CODE_E     = CW'(1);
    localparam logic [CW-1:0] CODE_L     = CW'(2);
    localparam logic [CW-1:0] CODE_O     = CW'(3);
    localparam logic [CW-1:0] CODE_BLANK = CW'(7);

    localparam logic [3:0] GAP_LAST = 4'(GAP_LEN);

    logic [2:0]    state;
    logic [3:0]    gap_cnt;
    logic [CW-1:0] char_code;
    logic          char_valid;
    logic          msg_start;
    logic          done;

    logic [2:0]    state_nxt;
    logic [3:0]    gap_nxt;
    logic [CW-1:0] code_nxt;
    logic          start_nxt;

    // Next values assuming the step is taken; the register block applies them only on step.
    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        code_nxt  = CODE_BLANK;
        start_nxt = 1'b0;
        case (state)
            IDLE: begin
                state_nxt = S_H;
                code_nxt  = CODE_H;
                start_nxt = 1'b1;
            end
            S_H: begin
                state_nxt = S_E;
                code_nxt  = CODE_E;
            end
            S_E: begin
                state_nxt = S_L1;
                code_nxt  = CODE_L;
            end
            S_L1: begin
                state_nxt = S_L2;
                code_nxt  = CODE_L;
            end
            S_L2: begin
                state_nxt = S_O;
                code_nxt  = CODE_O;
            end
            S_O, GAP: begin
                // With no gap configured, the step out of S_O takes the gap-exit decision directly.
                if ((state == S_O && GAP_LEN == 0) || (state == GAP && gap_cnt >= GAP_LAST)) begin
                    gap_nxt = 4'd0;
                    if (bus.loop_en) begin
                        state_nxt = S_H;
                        code_nxt  = CODE_H;
                        start_nxt = 1'b1;
                    end else begin
                        state_nxt = DONE;
                        code_nxt  = CODE_BLANK;
                    end
                end else begin
                    state_nxt = GAP;
                    code_nxt  = CODE_BLANK;
                    gap_nxt   = (state == S_O) ? 4'd1 : gap_cnt + 4'd1;
                end
            end
            DONE: begin
                state_nxt = DONE;
                code_nxt  = CODE_BLANK;
            end
            default: begin
                state_nxt = IDLE;
                code_nxt  = CODE_BLANK;
                gap_nxt   = 4'd0;
            end
        endcase
    end

    // Output register stage: code/state advance only on step, strobes follow step.
    always_ff @(posedge KEY) begin
        if (SW || bus.clear) begin
            state      <= IDLE;
            gap_cnt    <= 4'd0;
            char_code  <= CODE_BLANK;
            char_valid <= 1'b0;
            msg_start  <= 1'b0;
            done       <= 1'b0;
        end else begin
            char_valid <= bus.step;
            msg_start  <= bus.step & start_nxt;
            if (bus.step) begin
                state     <= state_nxt;
                gap_cnt   <= gap_nxt;
                char_code <= code_nxt;
                done      <= (state_nxt == DONE);
            end
        end
    end

    assign bus.char_code  = char_code;
    assign bus.char_valid = char_valid;
    assign bus.msg_start  = msg_start;
    assign bus.done       = done;
endmodule

// File: tb/tb_hello_msg_sequencer.sv
// Vector-table bench for hello_msg_sequencer: GAP_LEN=3 and GAP_LEN=0 instances share stimulus.
module tb_hello_msg_sequencer;
  logic KEY = 1'b0;
  logic SW  = 1'b1;

  hello_msg_sequencer_if #(.CW(3)) bus ();
  hello_msg_sequencer_if #(.CW(3)) bus0 ();

  hello_msg_sequencer #(.GAP_LEN(3), .CW(3)) dut (.KEY(KEY), .SW(SW), .bus(bus));
  hello_msg_sequencer #(.GAP_LEN(0), .CW(3)) dut0 (.KEY(KEY), .SW(SW), .bus(bus0));

  assign bus0.step    = bus.step;
  assign bus0.clear   = bus.clear;
  assign bus0.loop_en = bus.loop_en;

  always #5 KEY = ~KEY;

  typedef struct {
    logic       sw;
    logic       clr;
    logic       stp;
    logic       le;
    logic [2:0] code;
    logic       v;
    logic       s;
    logic       d;
    logic       g0;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(input logic sw, input logic clr, input logic stp, input logic le,
                              input logic [2:0] code, input logic v, input logic s,
                              input logic d, input logic g0 = 1'b0);
    vec_t t;
    t.sw = sw; t.clr = clr; t.stp = stp; t.le = le;
    t.code = code; t.v = v; t.s = s; t.d = d; t.g0 = g0;
    vecs.push_back(t);
  endfunction

  logic [2:0] lc [17] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7,
                           3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7, 3'd0};
  logic [2:0] ld [10] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7, 3'd7, 3'd7, 3'd7};
  logic [2:0] la [7]  = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7};
  logic [2:0] lg [7]  = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd0, 3'd1};
  logic [2:0] lg2 [7] = '{3'd0, 3'd1, 3'd2, 3'd2, 3'd3, 3'd7, 3'd7};

  initial begin
    vec_t e;
    logic [5:0] got;
    logic [5:0] exp;

    bus.step = 1'b0;
    bus.clear = 1'b0;
    bus.loop_en = 1'b0;

    // reset held two cycles
    add(1, 0, 0, 0, 3'd7, 0, 0, 0);
    add(1, 0, 0, 0, 3'd7, 0, 0, 0);
    // 17 continuous steps; loop_en only high at the two gap exits
    for (int i = 0; i < 17; i++)
      add(0, 0, 1, (i == 8 || i == 16), lc[i], 1, (i % 8 == 0), 0);
    add(0, 0, 0, 0, 3'd0, 0, 0, 0);
    // park: loop_en high mid-message, low only at the exit decision
    add(1, 0, 0, 0, 3'd7, 0, 0, 0);
    for (int i = 0; i < 10; i++)
      add(0, 0, 1, (i != 8), ld[i], 1, (i == 0), (i >= 8));
    add(0, 0, 0, 1, 3'd7, 0, 0, 1);
    add(0, 0, 0, 1, 3'd7, 0, 0, 1);
    add(0, 1, 1, 1, 3'd7, 0, 0, 0);
    // alternating step / idle
    for (int i = 0; i < 7; i++) begin
      add(0, 0, 1, 0, la[i], 1, (i == 0), 0);
      add(0, 0, 0, 0, la[i], 0, 0, 0);
    end
    add(0, 1, 0, 0, 3'd7, 0, 0, 0);
    // clear and reset each win over a simultaneous step
    add(0, 0, 1, 0, 3'd0, 1, 1, 0);
    add(0, 0, 1, 0, 3'd1, 1, 0, 0);
    add(0, 0, 1, 0, 3'd2, 1, 0, 0);
    add(0, 1, 1, 0, 3'd7, 0, 0, 0);
    add(0, 0, 1, 0, 3'd0, 1, 1, 0);
    add(1, 0, 1, 0, 3'd7, 0, 0, 0);
    add(0, 0, 1, 0, 3'd0, 1, 1, 0);
    // GAP_LEN=0 instance: repeat without blanks, then park straight after O
    add(1, 0, 0, 0, 3'd7, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++)
      add(0, 0, 1, 1, lg[i], 1, (i == 0 || i == 5), 0, 1);
    add(1, 0, 0, 0, 3'd7, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++)
      add(0, 0, 1, 0, lg2[i], 1, (i == 0), (i >= 5), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge KEY);
      SW          = vecs[i].sw;
      bus.clear   = vecs[i].clr;
      bus.step    = vecs[i].stp;
      bus.loop_en = vecs[i].le;
      sb.push_back(vecs[i]);
      @(posedge KEY);
      #1;
      e = sb.pop_front();
      if (e.g0)
        got = {bus0.char_code, bus0.char_valid, bus0.msg_start, bus0.done};
      else
        got = {bus.char_code, bus.char_valid, bus.msg_start, bus.done};
      exp = {e.code, e.v, e.s, e.d};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL vec%0d g0=%0d: got code=%0d valid=%b start=%b done=%b, expected code=%0d valid=%b start=%b done=%b",
                 i, e.g0, got[5:3], got[2], got[1], got[0], exp[5:3], exp[2], exp[1], exp[0]);
      end
    end

    // final reset-state check on both instances
    @(negedge KEY);
    SW          = 1'b1;
    bus.clear   = 1'b0;
    bus.step    = 1'b0;
    bus.loop_en = 1'b0;
    @(posedge KEY);
    #1;
    checks++;
    if ({bus.char_code, bus.char_valid, bus.msg_start, bus.done} !== 6'b111000) begin
      errors++;
      $display("FAIL reset GAP_LEN=3: got code=%0d valid=%b start=%b done=%b, expected code=7 valid=0 start=0 done=0",
               bus.char_code, bus.char_valid, bus.msg_start, bus.done);
    end
    checks++;
    if ({bus0.char_code, bus0.char_valid, bus0.msg_start, bus0.done} !== 6'b111000) begin
      errors++;
      $display("FAIL reset GAP_LEN=0: got code=%0d valid=%b start=%b done=%b, expected code=7 valid=0 start=0 done=0",
               bus0.char_code, bus0.char_valid, bus0.msg_start, bus0.done);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
